// File: rtl/dsp48a1_cmd_seq.sv
// dsp48a1_cmd_seq: valid/ready command sequencer for one fully pipelined DSP48A1 slice.
// Define DSP_SEQ_PCIN_LOOP_EN to feed each captured P back into PCIN for the next command.
module dsp48a1_cmd_seq #(
    parameter int LAT        = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [17:0] cmd_a,
    input  logic [17:0] cmd_b,
    input  logic [47:0] cmd_c,
    input  logic [17:0] cmd_d,
    input  logic [7:0]  cmd_opmode,
    input  logic        cmd_carryin,
    input  logic [47:0] cmd_pcin,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [47:0] dsp_c,
    output logic [47:0] dsp_pcin,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_carryin,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_p,
    output logic        res_carryout,
    output logic        busy
);

    localparam int CNT_MAX = (LAT > RST_CYCLES) ? LAT : RST_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST_ISSUE = CW'(LAT - 1);
    localparam logic [CW-1:0] LAST_RST   = CW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        RST_DSP,
        IDLE,
        ISSUE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;

    logic [17:0] a_q;
    logic [17:0] b_q;
    logic [17:0] d_q;
    logic [47:0] c_q;
    logic [47:0] pcin_q;
    logic [7:0]  op_q;
    logic        cin_q;
    logic        ce_q;
    logic        rst_q;
    logic        busy_q;

    logic        res_valid_q;
    logic        res_valid_d;
    logic [47:0] res_p_q;
    logic        res_co_q;

    logic slot_free;
    logic accept;
    logic capture;

    // A result consumed this very cycle frees the slot for a new command.
    assign slot_free = ~res_valid_q | res_ready;
    assign cmd_ready = (state_q == IDLE) & slot_free;
    assign accept    = cmd_valid & cmd_ready;
    assign capture   = (state_q == ISSUE) & (cnt_q == LAST_ISSUE);

    always_comb begin
        res_valid_d = res_valid_q;
        if (res_valid_q & res_ready) begin
            res_valid_d = 1'b0;
        end
        if (capture) begin
            res_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= RST_DSP;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            c_q         <= '0;
            pcin_q      <= '0;
            op_q        <= '0;
            cin_q       <= 1'b0;
            ce_q        <= 1'b0;
            rst_q       <= 1'b1;
            busy_q      <= 1'b1;
            res_valid_q <= 1'b0;
            res_p_q     <= '0;
            res_co_q    <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            if (capture) begin
                res_p_q  <= dsp_p;
                res_co_q <= dsp_carryout;
`ifdef DSP_SEQ_PCIN_LOOP_EN
                pcin_q   <= dsp_p;
`endif
            end
            unique case (state_q)
                RST_DSP: begin
                    if (cnt_q == LAST_RST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        rst_q   <= 1'b0;
                        ce_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        d_q     <= cmd_d;
                        c_q     <= cmd_c;
                        op_q    <= cmd_opmode;
                        cin_q   <= cmd_carryin;
`ifndef DSP_SEQ_PCIN_LOOP_EN
                        pcin_q  <= cmd_pcin;
`endif
                        state_q <= ISSUE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (capture) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RST_DSP;
                    cnt_q   <= '0;
                    rst_q   <= 1'b1;
                    ce_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef DSP_SEQ_PCIN_LOOP_EN
    logic unused_pcin;
    assign unused_pcin = ^cmd_pcin;
`endif

    assign dsp_a        = a_q;
    assign dsp_b        = b_q;
    assign dsp_d        = d_q;
    assign dsp_c        = c_q;
    assign dsp_pcin     = pcin_q;
    assign dsp_opmode   = op_q;
    assign dsp_carryin  = cin_q;
    assign dsp_ce       = ce_q;
    assign dsp_rst      = rst_q;
    assign res_valid    = res_valid_q;
    assign res_p        = res_p_q;
    assign res_carryout = res_co_q;
    assign busy         = busy_q;

endmodule
